// File: rtl/gate_bist_pkg.sv
// Shared FSM encoding and gate truth tables for the gate BIST checker.
// Truth tables are indexed by the stimulus pattern {in1,in2}.
package gate_bist_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        APPLY = 3'd1,
        WAIT  = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [3:0] GATE_AND  = 4'b1000;
    localparam logic [3:0] GATE_OR   = 4'b1110;
    localparam logic [3:0] GATE_XOR  = 4'b0110;
    localparam logic [3:0] GATE_NAND = 4'b0111;

    localparam logic [1:0] LAST_PAT  = 2'd3;

endpackage

// File: rtl/gate_bist_checker_settle_timer.sv
// Settle down-counter: loads a cycle count and flags its final cycle.
// Latency: expired is high in the value-th cycle after load; no backpressure.
// Backpressure: none, the counter free-runs down to zero and then idles.
module settle_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] value,
    output logic       expired
);

    logic [3:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 4'd0;
        end else if (load) begin
            cnt <= value;
        end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    // High in the last waiting cycle, so the FSM leaves WAIT after exactly value cycles.
    assign expired = (cnt == 4'd1);

endmodule

// File: rtl/gate_bist_checker.sv
// Built-in self test of a 2-input gate: walks the four patterns and counts mismatches.
// Latency: done pulses 4*(SETTLE+2) cycles after start is sampled; start is ignored while busy.
// Backpressure: none; optional resp_vec raw-response output enabled by GATE_BIST_RESP_EN.
module gate_bist_checker
    import gate_bist_pkg::*;
#(
    parameter logic [3:0]  EXPECT = GATE_AND,
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       dut_out,
    output logic       in1,
    output logic       in2,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_cnt,
    output logic [3:0] fail_vec
`ifdef GATE_BIST_RESP_EN
    ,
    output logic [3:0] resp_vec
`endif
);

    localparam logic [3:0] SETTLE_V = 4'(SETTLE);

    state_t     state, state_nxt;
    logic [1:0] idx;
    logic       load;
    logic       expired;
    logic       mismatch;
    logic       run_start;

    assign run_start = (state == IDLE) && start;
    assign mismatch  = (dut_out != EXPECT[idx]);

    settle_timer u_settle (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .value   (SETTLE_V),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE:    if (start) state_nxt = APPLY;
            APPLY: begin
                load      = 1'b1;
                state_nxt = WAIT;
            end
            WAIT:    if (expired) state_nxt = CHECK;
            CHECK:   state_nxt = (idx == LAST_PAT) ? DONE : APPLY;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == APPLY) || (state == WAIT) || (state == CHECK);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= 2'd0;
            in1      <= 1'b0;
            in2      <= 1'b0;
            pass     <= 1'b0;
            err_cnt  <= 3'd0;
            fail_vec <= 4'd0;
        end else begin
            if (run_start) begin
                idx      <= 2'd0;
                pass     <= 1'b0;
                err_cnt  <= 3'd0;
                fail_vec <= 4'd0;
            end
            if (state == APPLY) begin
                {in1, in2} <= idx;
            end
            if (state == CHECK) begin
                if (mismatch) begin
                    err_cnt       <= err_cnt + 3'd1;
                    fail_vec[idx] <= 1'b1;
                end
                // The index saturates at the last pattern; pass is settled on the way into DONE.
                if (idx != LAST_PAT) begin
                    idx <= idx + 2'd1;
                end else begin
                    pass <= (err_cnt == 3'd0) && !mismatch;
                end
            end
        end
    end

`ifdef GATE_BIST_RESP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_vec <= 4'd0;
        end else if (run_start) begin
            resp_vec <= 4'd0;
        end else if (state == CHECK) begin
            resp_vec[idx] <= dut_out;
        end
    end
`endif

endmodule

// File: tb/tb_gate_bist_checker.sv
// Self-checking bench: AND checker at SETTLE=2 plus an XOR checker at SETTLE=1 with start held high.
// Expected results come from truth-table arithmetic: fail_vec = response ^ expected table.
module tb_gate_bist_checker;
    import gate_bist_pkg::*;

    localparam int S0 = 2;
    localparam int S1 = 1;
    localparam int RUN0 = 4 * (S0 + 2);
    localparam int RUN1 = 4 * (S1 + 2);

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start0 = 1'b0;
    logic       dut_out0;
    logic       in1_0, in2_0, busy0, done0, pass0;
    logic [2:0] err0;
    logic [3:0] fv0;
    logic [3:0] rtab = 4'b0000;

    logic       start1 = 1'b0;
    logic       dut_out1;
    logic       in1_1, in2_1, busy1, done1, pass1;
    logic [2:0] err1;
    logic [3:0] fv1;
    logic [3:0] xtab = GATE_XOR;
`ifdef GATE_BIST_RESP_EN
    logic [3:0] resp0, resp1;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign dut_out0 = rtab[{in1_0, in2_0}];
    assign dut_out1 = xtab[{in1_1, in2_1}];

    gate_bist_checker #(.EXPECT(GATE_AND), .SETTLE(S0)) u_dut0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start0),
        .dut_out  (dut_out0),
        .in1      (in1_0),
        .in2      (in2_0),
        .busy     (busy0),
        .done     (done0),
        .pass     (pass0),
        .err_cnt  (err0),
        .fail_vec (fv0)
`ifdef GATE_BIST_RESP_EN
        ,
        .resp_vec (resp0)
`endif
    );

    gate_bist_checker #(.EXPECT(GATE_XOR), .SETTLE(S1)) u_dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start1),
        .dut_out  (dut_out1),
        .in1      (in1_1),
        .in2      (in2_1),
        .busy     (busy1),
        .done     (done1),
        .pass     (pass1),
        .err_cnt  (err1),
        .fail_vec (fv1)
`ifdef GATE_BIST_RESP_EN
        ,
        .resp_vec (resp1)
`endif
    );

    typedef struct {
        string      name;
        logic [3:0] tab;
        logic [2:0] err;
        logic [3:0] fv;
        logic       ps;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_in"},   32'({in1_0, in2_0}), 32'd0);
        check({name, "_busy"}, 32'(busy0), 32'd0);
        check({name, "_done"}, 32'(done0), 32'd0);
        check({name, "_pass"}, 32'(pass0), 32'd0);
        check({name, "_err"},  32'(err0), 32'd0);
        check({name, "_fv"},   32'(fv0), 32'd0);
`ifdef GATE_BIST_RESP_EN
        check({name, "_resp"}, 32'(resp0), 32'd0);
`endif
    endtask

    // One complete run on the AND checker; start may be toggled randomly while busy.
    task automatic run0(input string name, input logic [3:0] tab, input logic [2:0] exp_err,
                        input logic [3:0] exp_fv, input logic exp_ps, input bit noisy);
        int lat;
        int bcnt;
        rtab = tab;
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        check({name, "_clr_err"}, 32'(err0), 32'd0);
        check({name, "_clr_fv"}, 32'(fv0), 32'd0);
        check({name, "_clr_pass"}, 32'(pass0), 32'd0);
        lat = 0;
        bcnt = busy0 ? 1 : 0;
        while (!done0 && lat < 200) begin
            start0 = (noisy && lat < RUN0 - 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge clk);
            #1;
            lat++;
            if (busy0) bcnt++;
        end
        start0 = 1'b0;
        check({name, "_latency"}, 32'(lat), 32'(RUN0));
        check({name, "_busy_cycles"}, 32'(bcnt), 32'(RUN0));
        check({name, "_pass"}, 32'(pass0), 32'(exp_ps));
        check({name, "_err"}, 32'(err0), 32'(exp_err));
        check({name, "_fv"}, 32'(fv0), 32'(exp_fv));
`ifdef GATE_BIST_RESP_EN
        check({name, "_resp"}, 32'(resp0), 32'(tab));
`endif
        @(posedge clk);
        #1;
        check({name, "_done_pulse"}, 32'(done0), 32'd0);
        check({name, "_idle"}, 32'(busy0), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check({name, "_no_restart"}, 32'(busy0), 32'd0);
        check({name, "_pass_held"}, 32'(pass0), 32'(exp_ps));
        check({name, "_in_held"}, 32'({in1_0, in2_0}), 32'd3);
    endtask

    initial begin
        vecs[0] = '{"and_ok",  GATE_AND,  3'd0, 4'b0000, 1'b1};
        vecs[1] = '{"stuck0",  4'b0000,   3'd1, 4'b1000, 1'b0};
        vecs[2] = '{"stuck1",  4'b1111,   3'd3, 4'b0111, 1'b0};
        vecs[3] = '{"as_nand", GATE_NAND, 3'd4, 4'b1111, 1'b0};
        vecs[4] = '{"as_or",   GATE_OR,   3'd2, 4'b0110, 1'b0};

        #1;
        check_all_zero("reset");
        check("reset1_busy", 32'(busy1), 32'd0);
        check("reset1_done", 32'(done1), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_no_start", 32'(busy0), 32'd0);

        for (int i = 0; i < 5; i++) begin
            run0(vecs[i].name, vecs[i].tab, vecs[i].err, vecs[i].fv, vecs[i].ps, 1'b0);
        end

        // Randomised responses with random start chatter during the run.
        for (int i = 0; i < 12; i++) begin
            logic [3:0] tab;
            logic [3:0] fv;
            tab = 4'($urandom_range(0, 15));
            fv  = tab ^ GATE_AND;
            run0($sformatf("rand%0d", i), tab, 3'($countones(fv)), fv, fv == 4'd0, 1'b1);
        end

        // Reset during WAIT of pattern 2 with partial errors already counted.
        rtab = 4'b1111;
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        repeat (S0 + 2 + S0 + 2 + 1) @(posedge clk);
        #1;
        check("mid_pattern", 32'({in1_0, in2_0}), 32'd2);
        check("mid_err", 32'(err0), 32'd2);
        check("mid_busy", 32'(busy0), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        run0("after_rst", GATE_AND, 3'd0, 4'b0000, 1'b1, 1'b0);

        // XOR checker, SETTLE=1, start held high: back-to-back runs.
        begin
            int ndone;
            int last;
            ndone = 0;
            last = 0;
            @(negedge clk);
            start1 = 1'b1;
            for (int c = 0; c < 100 && ndone < 4; c++) begin
                @(posedge clk);
                #1;
                if (done1) begin
                    if (ndone == 0) check("held_first_lat", 32'(c), 32'(RUN1));
                    else check("held_period", 32'(c - last), 32'(RUN1 + 2));
                    check("held_busy_in_done", 32'(busy1), 32'd0);
                    check("held_pass", 32'(pass1), 32'd1);
                    check("held_err", 32'(err1), 32'd0);
                    check("held_fv", 32'(fv1), 32'd0);
`ifdef GATE_BIST_RESP_EN
                    check("held_resp", 32'(resp1), 32'(GATE_XOR));
`endif
                    last = c;
                    ndone++;
                end
            end
            start1 = 1'b0;
            check("held_done_count", 32'(ndone), 32'd4);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
